mmio_bridge: RTL and testbench

System bridge between the CPU's memory-mapped I/O port and the peripheral set (timer0, timer1, switch input, LED driver, digital tube). Decodes the word address and posts each store through a one-entry write buffer, so every peripheral sees a registered, word-wide write one cycle after the CPU issues it. Sub-word stores are byte-merged against the target's current read-back, because the peripherals accept full words only. Loads are returned the same cycle, with bypass from the pending write.

---
 rtl/mmio_map_pkg.sv | 40 ++++
 rtl/mmio_addr_decode.sv | 29 ++
 rtl/mmio_bridge.sv | 113 +++++++++++
 tb/tb_mmio_bridge.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/mmio_map_pkg.sv
// rtl/mmio_map_pkg.sv - address map, device ids and helpers for the MMIO bridge
package mmio_map_pkg;

  localparam logic [31:0] T0_BASE_DEF   = 32'h0000_7f00;
  localparam logic [31:0] T1_BASE_DEF   = 32'h0000_7f10;
  localparam logic [31:0] SW_BASE_DEF   = 32'h0000_7f2c;
  localparam logic [31:0] LED_BASE_DEF  = 32'h0000_7f34;
  localparam logic [31:0] TUBE_BASE_DEF = 32'h0000_7f38;

  localparam int unsigned T0_WORDS   = 3;
  localparam int unsigned T1_WORDS   = 3;
  localparam int unsigned SW_WORDS   = 2;
  localparam int unsigned LED_WORDS  = 1;
  localparam int unsigned TUBE_WORDS = 2;

  typedef enum logic [2:0] {
    DEV_NONE = 3'd0,
    DEV_T0   = 3'd1,
    DEV_T1   = 3'd2,
    DEV_SW   = 3'd3,
    DEV_LED  = 3'd4,
    DEV_TUBE = 3'd5
  } dev_id_e;

  function automatic logic dev_writable(input dev_id_e d);
    case (d)
      DEV_T0, DEV_T1, DEV_LED, DEV_TUBE: dev_writable = 1'b1;
      default:                           dev_writable = 1'b0;
    endcase
  endfunction

  // Inclusive range check on word addresses: base .. base+cnt-1.
  function automatic logic word_in_range(input logic [29:0] w, input logic [31:0] base,
                                         input int unsigned cnt);
    logic [29:0] b;
    b = base[31:2];
    word_in_range = (w >= b) && (w < b + cnt[29:0]);
  endfunction

endpackage

// File: rtl/mmio_addr_decode.sv
// rtl/mmio_addr_decode.sv - combinational word address to device id decoder
module mmio_addr_decode
  import mmio_map_pkg::*;
#(
  parameter logic [31:0] T0_BASE   = T0_BASE_DEF,
  parameter logic [31:0] T1_BASE   = T1_BASE_DEF,
  parameter logic [31:0] SW_BASE   = SW_BASE_DEF,
  parameter logic [31:0] LED_BASE  = LED_BASE_DEF,
  parameter logic [31:0] TUBE_BASE = TUBE_BASE_DEF
) (
  input  logic [29:0] i_word,
  output dev_id_e     o_dev
);

  always_comb begin
    o_dev = DEV_NONE;
    if (word_in_range(i_word, T0_BASE, T0_WORDS))
      o_dev = DEV_T0;
    else if (word_in_range(i_word, T1_BASE, T1_WORDS))
      o_dev = DEV_T1;
    else if (word_in_range(i_word, SW_BASE, SW_WORDS))
      o_dev = DEV_SW;
    else if (word_in_range(i_word, LED_BASE, LED_WORDS))
      o_dev = DEV_LED;
    else if (word_in_range(i_word, TUBE_BASE, TUBE_WORDS))
      o_dev = DEV_TUBE;
  end

endmodule

// File: rtl/mmio_bridge.sv
// rtl/mmio_bridge.sv - CPU MMIO to peripheral bridge with one-entry posted write buffer
module mmio_bridge
  import mmio_map_pkg::*;
#(
  parameter logic [31:0] T0_BASE   = T0_BASE_DEF,
  parameter logic [31:0] T1_BASE   = T1_BASE_DEF,
  parameter logic [31:0] SW_BASE   = SW_BASE_DEF,
  parameter logic [31:0] LED_BASE  = LED_BASE_DEF,
  parameter logic [31:0] TUBE_BASE = TUBE_BASE_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PrAddr,
  input  logic [31:0] PrWD,
  input  logic [3:0]  PrBE,
  input  logic        PrWE,
  output logic [31:0] PrRD,
  output logic        PrStall,
  output logic [31:0] DEV_Addr,
  output logic [31:0] DEV_WD,
  output logic        WE_T0,
  output logic        WE_T1,
  output logic        WE_LED,
  output logic        WE_TUBE,
  input  logic [31:0] T0_RD,
  input  logic [31:0] T1_RD,
  input  logic [31:0] SW_RD,
  input  logic [31:0] LED_RD,
  input  logic [31:0] TUBE_RD
);

  logic [29:0] w_word;
  dev_id_e     w_dev;
  logic [31:0] w_dev_rd;
  logic [31:0] w_mask;
  logic [31:0] w_merged;
  logic        w_hit;
  logic        w_stall;
  logic        w_accept;
  logic        w_we_en;

  logic        r_valid;
  logic [29:0] r_addr;
  logic [31:0] r_data;
  dev_id_e     r_dev;

  assign w_word = PrAddr[31:2];

  mmio_addr_decode #(
    .T0_BASE   (T0_BASE),
    .T1_BASE   (T1_BASE),
    .SW_BASE   (SW_BASE),
    .LED_BASE  (LED_BASE),
    .TUBE_BASE (TUBE_BASE)
  ) u_decode (
    .i_word (w_word),
    .o_dev  (w_dev)
  );

  always_comb begin
    w_dev_rd = 32'h0;
    case (w_dev)
      DEV_T0:   w_dev_rd = T0_RD;
      DEV_T1:   w_dev_rd = T1_RD;
      DEV_SW:   w_dev_rd = SW_RD;
      DEV_LED:  w_dev_rd = LED_RD;
      DEV_TUBE: w_dev_rd = TUBE_RD;
      default:  w_dev_rd = 32'h0;
    endcase
  end

  always_comb begin
    w_mask = 32'h0;
    for (int i = 0; i < 4; i++)
      w_mask[8*i +: 8] = {8{PrBE[i]}};
  end

  assign w_merged = (w_dev_rd & ~w_mask) | (PrWD & w_mask);

  // A partial store to the pending word must wait: its read-back is stale until the commit lands.
  assign w_hit    = r_valid && (r_addr == w_word);
  assign w_stall  = PrWE && (PrBE != 4'b1111) && w_hit;
  assign w_accept = PrWE && (PrBE != 4'b0000) && !w_stall && dev_writable(w_dev);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_addr  <= 30'h0;
      r_data  <= 32'h0;
      r_dev   <= DEV_NONE;
    end else begin
      r_valid <= w_accept;
      if (w_accept) begin
        r_addr <= w_word;
        r_data <= w_merged;
        r_dev  <= w_dev;
      end
    end
  end

  // Strobes are masked by reset so a pending write is discarded the moment reset is raised.
  assign w_we_en  = r_valid && !reset;
  assign WE_T0    = w_we_en && (r_dev == DEV_T0);
  assign WE_T1    = w_we_en && (r_dev == DEV_T1);
  assign WE_LED   = w_we_en && (r_dev == DEV_LED);
  assign WE_TUBE  = w_we_en && (r_dev == DEV_TUBE);

  assign DEV_Addr = {r_addr, 2'b00};
  assign DEV_WD   = r_data;
  assign PrStall  = w_stall;
  assign PrRD     = w_hit ? r_data : w_dev_rd;

endmodule

// File: tb/tb_mmio_bridge.sv
// tb/tb_mmio_bridge.sv - directed self-checking bench for mmio_bridge
module tb_mmio_bridge;

  logic        clk;
  logic        reset;
  logic [31:0] PrAddr;
  logic [31:0] PrWD;
  logic [3:0]  PrBE;
  logic        PrWE;
  logic [31:0] PrRD;
  logic        PrStall;
  logic [31:0] DEV_Addr;
  logic [31:0] DEV_WD;
  logic        WE_T0, WE_T1, WE_LED, WE_TUBE;
  logic [31:0] T0_RD, T1_RD, SW_RD, LED_RD, TUBE_RD;

  int checks;
  int failures;

  mmio_bridge dut (
    .clk      (clk),
    .reset    (reset),
    .PrAddr   (PrAddr),
    .PrWD     (PrWD),
    .PrBE     (PrBE),
    .PrWE     (PrWE),
    .PrRD     (PrRD),
    .PrStall  (PrStall),
    .DEV_Addr (DEV_Addr),
    .DEV_WD   (DEV_WD),
    .WE_T0    (WE_T0),
    .WE_T1    (WE_T1),
    .WE_LED   (WE_LED),
    .WE_TUBE  (WE_TUBE),
    .T0_RD    (T0_RD),
    .T1_RD    (T1_RD),
    .SW_RD    (SW_RD),
    .LED_RD   (LED_RD),
    .TUBE_RD  (TUBE_RD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] be);
    PrWE   = we;
    PrAddr = addr;
    PrWD   = wd;
    PrBE   = be;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 32'h0, 4'b0000);
  endtask

  function automatic logic [31:0] we_vec();
    return {28'h0, WE_T0, WE_T1, WE_LED, WE_TUBE};
  endfunction

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    PrWE = 1'b0; PrAddr = 32'h0; PrWD = 32'h0; PrBE = 4'b0000;
    T0_RD = 32'h0101_0101; T1_RD = 32'h0202_0202; SW_RD = 32'h0000_00C3;
    LED_RD = 32'h0; TUBE_RD = 32'h1234_5678;
    tick(); tick();
    reset = 1'b0;
    #1;
    check("rst_we",    we_vec(), 32'h0);
    check("rst_wd",    DEV_WD, 32'h0);
    check("rst_addr",  DEV_Addr, 32'h0);
    check("rst_stall", {31'h0, PrStall}, 32'h0);

    // Full-word store to LED
    drive(1'b1, 32'h0000_7f34, 32'hA5A5_5A5A, 4'b1111);
    check("led_sw_stall", {31'h0, PrStall}, 32'h0);
    tick(); idle();
    check("led_sw_we",   we_vec(), 32'h2);
    check("led_sw_wd",   DEV_WD, 32'hA5A5_5A5A);
    check("led_sw_addr", DEV_Addr, 32'h0000_7f34);
    tick();
    check("led_sw_we_n2", we_vec(), 32'h0);

    // Byte store merged against LED read-back
    LED_RD = 32'h1122_3344;
    drive(1'b1, 32'h0000_7f34, 32'h0000_00FF, 4'b0001);
    check("sb_stall", {31'h0, PrStall}, 32'h0);
    tick(); idle();
    check("sb_we", we_vec(), 32'h2);
    check("sb_wd", DEV_WD, 32'h1122_33FF);
    tick();

    // Partial store to the pending word stalls one cycle
    drive(1'b1, 32'h0000_7f34, 32'h0000_0000, 4'b1111);
    tick();
    drive(1'b1, 32'h0000_7f36, 32'hBEEF_0000, 4'b1100);
    check("sh_stall_n1", {31'h0, PrStall}, 32'h1);
    check("sh_we_n1",    we_vec(), 32'h2);
    check("sh_wd_n1",    DEV_WD, 32'h0);
    LED_RD = 32'h0;
    tick();
    #1;
    check("sh_stall_n2", {31'h0, PrStall}, 32'h0);
    check("sh_we_n2",    we_vec(), 32'h0);
    tick(); idle();
    check("sh_we_n3", we_vec(), 32'h2);
    check("sh_wd_n3", DEV_WD, 32'hBEEF_0000);
    tick();

    // Read-only and unmapped stores are dropped
    drive(1'b1, 32'h0000_7f2c, 32'hDEAD_BEEF, 4'b1111);
    tick(); idle();
    check("sw_ro_we", we_vec(), 32'h0);
    drive(1'b1, 32'h0000_7f40, 32'hDEAD_BEEF, 4'b1111);
    tick();
    drive(1'b0, 32'h0000_7f40, 32'h0, 4'b1111);
    check("unmap_we", we_vec(), 32'h0);
    check("unmap_rd", PrRD, 32'h0);
    drive(1'b0, 32'h0000_7f30, 32'h0, 4'b1111);
    check("sw_rd", PrRD, 32'h0000_00C3);

    // Load bypass from the pending store
    drive(1'b1, 32'h0000_7f38, 32'hCAFE_F00D, 4'b1111);
    tick();
    drive(1'b0, 32'h0000_7f38, 32'h0, 4'b1111);
    check("byp_rd", PrRD, 32'hCAFE_F00D);
    check("byp_we", we_vec(), 32'h1);
    tick();
    check("tube_rd", PrRD, 32'h1234_5678);
    drive(1'b0, 32'h0000_7f04, 32'h0, 4'b1111);
    check("t0_rd", PrRD, 32'h0101_0101);

    // Back-to-back full stores, then full store to the same word
    drive(1'b1, 32'h0000_7f00, 32'h1111_1111, 4'b1111);
    tick();
    drive(1'b1, 32'h0000_7f04, 32'h2222_2222, 4'b1111);
    check("b2b_stall0", {31'h0, PrStall}, 32'h0);
    check("b2b_addr0", DEV_Addr, 32'h0000_7f00);
    check("b2b_we0", we_vec(), 32'h8);
    tick();
    drive(1'b1, 32'h0000_7f04, 32'h3333_3333, 4'b1111);
    check("same_full_stall", {31'h0, PrStall}, 32'h0);
    check("b2b_wd1", DEV_WD, 32'h2222_2222);
    check("b2b_addr1", DEV_Addr, 32'h0000_7f04);
    tick(); idle();
    check("same_full_wd", DEV_WD, 32'h3333_3333);
    check("same_full_we", we_vec(), 32'h8);
    tick();

    // Reset while a store to timer1 is pending
    drive(1'b1, 32'h0000_7f10, 32'h5555_AAAA, 4'b1111);
    tick(); idle();
    reset = 1'b1;
    #1;
    check("rst_pend_we_n1", we_vec(), 32'h0);
    tick();
    reset = 1'b0;
    #1;
    check("rst_pend_we_n2", we_vec(), 32'h0);
    check("rst_pend_wd",    DEV_WD, 32'h0);
    check("rst_pend_addr",  DEV_Addr, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
